// File: rtl/mgc_axi_slv_pkg.sv
// ---------------------------------------------------------------------------
// mgc_axi_slv_pkg
// Shared types and constants for the AXI4 write-channel slave endpoint:
//   - BRESP codes (OKAY / SLVERR)
//   - AWBURST encodings (FIXED / INCR / WRAP)
//   - write FSM state enum
//   - aw_entry_t, one buffered write-address request
//   - aw_entry_err(), the error classification applied when a burst starts
// aw_entry_t fields are sized for the widest supported configuration. The
// endpoint zero-extends AWADDR/AWID into them.
// ---------------------------------------------------------------------------
package mgc_axi_slv_pkg;

    localparam int unsigned AXI_MAX_ADDR_W = 64;
    localparam int unsigned AXI_MAX_ID_W   = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } wr_state_e;

    typedef struct packed {
        logic [AXI_MAX_ADDR_W-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [AXI_MAX_ID_W-1:0]   id;
    } aw_entry_t;

    // A burst is rejected when any of these holds:
    //   - its beat size is not the full bus width;
    //   - it is WRAP or the reserved encoding (burst[1] set);
    //   - its last beat addresses a word beyond the local memory.
    function automatic logic aw_entry_err(input aw_entry_t   e,
                                          input int unsigned size_log2,
                                          input int unsigned mem_aw);
        logic [AXI_MAX_ADDR_W-1:0] first_word;
        logic [AXI_MAX_ADDR_W-1:0] last_word;
        first_word = e.addr >> size_log2;
        last_word  = first_word +
                     ((e.burst == BURST_INCR) ? AXI_MAX_ADDR_W'(e.len)
                                              : '0);
        return (e.size != 3'(size_log2)) || e.burst[1] ||
               ((last_word >> mem_aw) != '0);
    endfunction

endpackage

// File: rtl/mgc_axi_slv_aw_fifo.sv
// ---------------------------------------------------------------------------
// mgc_axi_slv_aw_fifo
// Synchronous FIFO of aw_entry_t used to buffer AXI write addresses.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - push request; accepted only while push_ready
//   push_data   - entry to push
//   push_ready  - registered !full, computed from the next-state occupancy
//                 (0 while in reset)
//   pop         - pop request; ignored while empty
//   head        - entry at the read pointer
//   full, empty - occupancy flags
// DEPTH must be a power of 2 and at least 2. Pointers then wrap naturally.
// ---------------------------------------------------------------------------
module mgc_axi_slv_aw_fifo
    import mgc_axi_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  aw_entry_t push_data,
    output logic      push_ready,
    input  logic      pop,
    output aw_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    aw_entry_t     store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && push_ready;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign head    = store[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            count      <= count_nxt;
            push_ready <= (count_nxt != (PW+1)'(DEPTH));
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mgc_axi_slave_wr_endpoint.sv
// ---------------------------------------------------------------------------
// mgc_axi_slave_wr_endpoint
// AXI4 write-channel slave endpoint. It buffers AW requests in a FIFO,
// stores W beats into a local word memory and returns one B response per
// burst. A backdoor port reads the memory with one cycle of latency.
// Ports:
//   ACLK, ARESETn                   - clock, asynchronous active-low reset
//   AW*  (VALID/READY/ADDR/LEN/SIZE/BURST/ID) - write address channel
//   W*   (VALID/READY/DATA/STRB/LAST)       - write data channel
//   B*   (VALID/READY/ID/RESP)              - write response channel
//   dbg_addr / dbg_data             - backdoor word index / registered read data
// Build option: MGC_AXI_SLV_WSTRB_EN
//   When defined, WSTRB masks writes per byte lane.
//   When undefined, every accepted beat writes the full word.
// ---------------------------------------------------------------------------
module mgc_axi_slave_wr_endpoint
    import mgc_axi_slv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AW_DEPTH   = 4,
    parameter int unsigned MEM_AW     = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    input  logic [MEM_AW-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0]   dbg_data
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned SZ_LOG = $clog2(STRB_W);

    aw_entry_t aw_in;
    aw_entry_t aw_head;
    logic      aw_full;
    logic      aw_empty;
    logic      aw_pop;

    wr_state_e           state;
    logic [MEM_AW-1:0]   b_widx;
    logic [7:0]          b_len;
    logic [ID_WIDTH-1:0] b_id;
    logic                b_err;
    logic                b_fixed;
    logic [7:0]          beat_cnt;
    logic                w_hs;
    logic                mem_we;

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    assign aw_in = '{addr:  AXI_MAX_ADDR_W'(AWADDR),
                     len:   AWLEN,
                     size:  AWSIZE,
                     burst: AWBURST,
                     id:    AXI_MAX_ID_W'(AWID)};

    mgc_axi_slv_aw_fifo #(
        .DEPTH (AW_DEPTH)
    ) u_aw_fifo (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .push       (AWVALID),
        .push_data  (aw_in),
        .push_ready (AWREADY),
        .pop        (aw_pop),
        .head       (aw_head),
        .full       (aw_full),
        .empty      (aw_empty)
    );

    // The next burst is popped either from IDLE or during the B handshake.
    // In RESP, BVALID is always 1, so BREADY alone marks the handshake.
    assign aw_pop = !aw_empty &&
                    ((state == ST_IDLE) || ((state == ST_RESP) && BREADY));

    assign w_hs   = WVALID && WREADY;
    assign mem_we = w_hs && !b_err && (beat_cnt <= b_len);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ST_IDLE;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= '0;
            BRESP    <= RESP_OKAY;
            b_widx   <= '0;
            b_len    <= '0;
            b_id     <= '0;
            b_err    <= 1'b0;
            b_fixed  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_DATA: begin
                    if (w_hs) begin
                        if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                        if (!b_fixed) b_widx <= b_widx + MEM_AW'(1);
                        if (WLAST) begin
                            state  <= ST_RESP;
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BID    <= b_id;
                            // Early or late WLAST is reported as SLVERR.
                            BRESP  <= (b_err || (beat_cnt != b_len)) ?
                                      RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                ST_RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A pop can happen in IDLE or in RESP, so the burst load is shared
            // here and overrides the per-state transition.
            if (aw_pop) begin
                state    <= ST_DATA;
                WREADY   <= 1'b1;
                b_widx   <= aw_head.addr[SZ_LOG +: MEM_AW];
                b_len    <= aw_head.len;
                b_id     <= aw_head.id[ID_WIDTH-1:0];
                b_err    <= aw_entry_err(aw_head, SZ_LOG, MEM_AW);
                b_fixed  <= (aw_head.burst == BURST_FIXED);
                beat_cnt <= '0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
`ifdef MGC_AXI_SLV_WSTRB_EN
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[b_widx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
`else
            mem[b_widx] <= WDATA;
`endif
        end
    end

`ifndef MGC_AXI_SLV_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^WSTRB;
`endif

    logic unused_aw_full;
    assign unused_aw_full = aw_full;

    // Nonblocking read: a same-cycle write to the same word returns old data.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_mgc_axi_slave_wr_endpoint.sv
module tb_mgc_axi_slave_wr_endpoint;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWID;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 ACLK = ~ACLK;

    mgc_axi_slave_wr_endpoint #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .AW_DEPTH   (4),
        .MEM_AW     (8)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWID     (AWID),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    b_exp_t      b_q[$];
    logic [31:0] dbg_q[$];
    logic        dbg_go = 1'b0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, between driven edges.
    initial begin
        b_exp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESETn === 1'b1 && BVALID === 1'b1 && BREADY === 1'b1) begin
                if (b_q.size() == 0) begin
                    n_total++;
                    $display("FAIL b_unexpected: got BID=0x%0h BRESP=0x%0h expected no response", BID, BRESP);
                end else begin
                    e = b_q.pop_front();
                    check("bid", 64'(BID), 64'(e.id));
                    check("bresp", 64'(BRESP), 64'(e.resp));
                end
            end
            if (dbg_go) begin
                if (dbg_q.size() == 0) begin
                    n_total++;
                    $display("FAIL dbg_unexpected: got 0x%0h expected no read", dbg_data);
                end else begin
                    check("dbg_data", 64'(dbg_data), 64'(dbg_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [1:0] resp);
        b_q.push_back('{id: id, resp: resp});
        AWADDR  = a;
        AWLEN   = len;
        AWSIZE  = size;
        AWBURST = burst;
        AWID    = id;
        AWVALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (AWREADY) begin
                @(posedge ACLK);
                #1;
                AWVALID = 1'b0;
                return;
            end
        end
        n_total++;
        $display("FAIL aw_timeout: got no AWREADY expected handshake id=%0d", id);
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
        WDATA  = d;
        WSTRB  = strb;
        WLAST  = last;
        WVALID = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge ACLK);
            if (WREADY) begin
                @(posedge ACLK);
                #1;
                WVALID = 1'b0;
                WLAST  = 1'b0;
                return;
            end
        end
        n_total++;
        $display("FAIL w_timeout: got no WREADY expected handshake data=0x%0h", d);
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic dbg_read(input logic [7:0] a, input logic [31:0] exp);
        dbg_addr = a;
        dbg_q.push_back(exp);
        tick();
        dbg_go = 1'b1;
        tick();
        dbg_go = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (b_q.size() == 0) return;
        end
        n_total++;
        $display("FAIL b_timeout: got %0d pending expected 0", b_q.size());
        b_q.delete();
    endtask

    initial begin
        ARESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = INCR; AWID = '0;
        WVALID = 1'b0; WDATA = '0; WSTRB = 4'hF; WLAST = 1'b0;
        BREADY = 1'b1; dbg_addr = '0;
        #1;
        check("rst_awready", 64'(AWREADY), 0);
        check("rst_wready", 64'(WREADY), 0);
        check("rst_bvalid", 64'(BVALID), 0);
        check("rst_bid", 64'(BID), 0);
        check("rst_bresp", 64'(BRESP), 0);
        check("rst_dbg", 64'(dbg_data), 0);
        tick(); tick();
        ARESETn = 1'b1;
        tick();
        check("awready_after_rst", 64'(AWREADY), 1);

        // single INCR beat
        send_aw(32'h10, 8'd0, 3'd2, INCR, 4'd3, OKAY);
        send_w(32'hDEADBEEF, 4'hF, 1'b1);
        drain();
        dbg_read(8'd4, 32'hDEADBEEF);

        // 4-beat INCR burst
        send_aw(32'h0, 8'd3, 3'd2, INCR, 4'd5, OKAY);
        for (int k = 1; k <= 4; k++) send_w(32'(k), 4'hF, k == 4);
        drain();
        for (int k = 0; k < 4; k++) dbg_read(8'(k), 32'(k + 1));
        check("single_b_bvalid", 64'(BVALID), 0);

        // W before AW
        fork
            send_w(32'hCAFE0001, 4'hF, 1'b1);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge ACLK);
                    check("w_early_wready", 64'(WREADY), 0);
                end
                tick();
                send_aw(32'h20, 8'd0, 3'd2, INCR, 4'd6, OKAY);
            end
        join
        drain();
        dbg_read(8'd8, 32'hCAFE0001);

        // FIXED burst: every beat hits the same word
        send_aw(32'h50, 8'd2, 3'd2, FIXED, 4'd7, OKAY);
        send_w(32'hA, 4'hF, 1'b0);
        send_w(32'hB, 4'hF, 1'b0);
        send_w(32'hC, 4'hF, 1'b1);
        drain();
        dbg_read(8'd20, 32'hC);

        // back-pressure: one in flight plus four buffered
        BREADY = 1'b0;
        for (int k = 0; k < 5; k++) send_aw(32'h100 + 32'(4 * k), 8'd0, 3'd2, INCR, 4'(k + 1), OKAY);
        @(negedge ACLK);
        check("bp_awready_full", 64'(AWREADY), 0);
        tick();
        send_w(32'h5A5A0001, 4'hF, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check("bp_bvalid_held", 64'(BVALID), 1);
            check("bp_bid_stable", 64'(BID), 1);
        end
        check("bp_awready_still_full", 64'(AWREADY), 0);
        tick();
        BREADY = 1'b1;
        for (int k = 1; k < 5; k++) send_w(32'h5A5A0001 + 32'(k), 4'hF, 1'b1);
        drain();
        dbg_read(8'd64, 32'h5A5A0001);
        dbg_read(8'd68, 32'h5A5A0005);

        // error bursts leave memory unchanged
        send_aw(32'h40, 8'd0, 3'd2, INCR, 4'd7, OKAY);
        send_w(32'hA5A50016, 4'hF, 1'b1);
        send_aw(32'h3FC, 8'd0, 3'd2, INCR, 4'd7, OKAY);
        send_w(32'hBBBB00FF, 4'hF, 1'b1);
        send_aw(32'h40, 8'd0, 3'd2, WRAP, 4'd8, SLVERR);
        send_w(32'h1111, 4'hF, 1'b1);
        send_aw(32'h40, 8'd0, 3'd1, INCR, 4'd9, SLVERR);
        send_w(32'h2222, 4'hF, 1'b1);
        send_aw(32'h400, 8'd0, 3'd2, INCR, 4'd10, SLVERR);
        send_w(32'h3333, 4'hF, 1'b1);
        send_aw(32'h3FC, 8'd1, 3'd2, INCR, 4'd11, SLVERR);
        send_w(32'h4444, 4'hF, 1'b0);
        send_w(32'h5555, 4'hF, 1'b1);
        // early WLAST: the first two beats are written
        send_aw(32'h80, 8'd3, 3'd2, INCR, 4'd12, SLVERR);
        send_w(32'h80, 4'hF, 1'b0);
        send_w(32'h81, 4'hF, 1'b1);
        // beat beyond len is discarded
        send_aw(32'h90, 8'd0, 3'd2, INCR, 4'd13, SLVERR);
        send_w(32'h90, 4'hF, 1'b0);
        send_w(32'h91, 4'hF, 1'b1);
        drain();
        dbg_read(8'd16, 32'hA5A50016);
        dbg_read(8'd0, 32'h1);
        dbg_read(8'd255, 32'hBBBB00FF);
        dbg_read(8'd32, 32'h80);
        dbg_read(8'd33, 32'h81);
        dbg_read(8'd36, 32'h90);

        // reset mid-burst
        send_aw(32'h60, 8'd3, 3'd2, INCR, 4'd14, OKAY);
        send_w(32'h77, 4'hF, 1'b0);
        #2;
        ARESETn = 1'b0;
        #1;
        check("midrst_awready", 64'(AWREADY), 0);
        check("midrst_wready", 64'(WREADY), 0);
        check("midrst_bvalid", 64'(BVALID), 0);
        b_q.delete();
        tick();
        ARESETn = 1'b1;
        tick();
        dbg_read(8'd24, 32'h77);
        send_aw(32'h60, 8'd0, 3'd2, INCR, 4'd15, OKAY);
        send_w(32'h99, 4'hF, 1'b1);
        drain();
        dbg_read(8'd24, 32'h99);

        // byte strobes
        send_aw(32'h70, 8'd0, 3'd2, INCR, 4'd1, OKAY);
        send_w(32'hFFFFFFFF, 4'hF, 1'b1);
        send_aw(32'h70, 8'd0, 3'd2, INCR, 4'd2, OKAY);
        send_w(32'h0, 4'b0101, 1'b1);
        drain();
`ifdef MGC_AXI_SLV_WSTRB_EN
        dbg_read(8'd28, 32'hFF00FF00);
`else
        dbg_read(8'd28, 32'h0);
`endif

        tick(); tick();
        check("b_queue_empty", 64'(b_q.size()), 0);
        check("dbg_queue_empty", 64'(dbg_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
